wb_tx_frame_fetch: RTL
======================

Name: wb_tx_frame_fetch

Overview:
- Wishbone master read engine, directly upstream of the Wishbone slave memory model: drives the m_wb_* master signals and consumes its ack/err/rty terminations.
- Fetches a TX frame of LEN 32-bit words from word-indexed memory, starting at a given word address.
- Buffers the words in an internal FIFO and presents them as a valid/ready stream with a last flag.
- Handles wait states, retry back-off, error termination and a response timeout.

Parameters:
- AW, 32, address width (word address; increments by 1 per word).
- DW, 32, data width.
- FIFO_DEPTH, 8, stream buffer depth in words (power of 2, at least 2).
- MAX_RETRY, 8, rty terminations tolerated per word before abort.
- TIMEOUT, 64, cycles with stb high and no termination before abort.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; starts a fetch when IDLE.
- start_adr_i  in  AW  first word address, sampled on start_i.
- len_i  in  16  word count, sampled on start_i.
- abort_i  in  1  software abort.
- busy_o  out  1  high from accepted start until done_o.
- done_o  out  1  one-cycle completion pulse.
- status_o  out  2  result, valid with done_o and held until next start: 00 ok, 01 err, 10 retry exhausted, 11 timeout/abort.
- m_wb_adr_o  out  AW  bus address.
- m_wb_sel_o  out  4  always 4'hF while cyc is high, else 0.
- m_wb_we_o  out  1  always 0.
- m_wb_cyc_o  out  1  bus cycle.
- m_wb_stb_o  out  1  strobe.
- m_wb_dat_i  in  DW  read data.
- m_wb_ack_i, m_wb_err_i, m_wb_rty_i  in  1 each  terminations.
- tx_data_o  out  DW  stream data (FIFO head).
- tx_valid_o  out  1  stream valid.
- tx_last_o  out  1  marks the final word of the frame.
- tx_ready_i  in  1  stream ready.

Behaviour:
- Reset (async, wb_rst_i low):
  - state IDLE; all outputs 0, including adr, sel, status, tx_data.
  - FIFO empty; retry and timeout counters 0.
- States and transitions:
  - IDLE:
    - start_i with len_i == 0 → next cycle done_o=1, status=00, no bus cycle.
    - start_i with len_i > 0 → latch adr/len, busy_o=1, go to CHECK.
  - CHECK:
    - If the FIFO has at least one free slot → REQ.
    - Otherwise stay; cyc and stb low.
  - REQ: cyc=stb=1, adr=current address. Terminations are sampled each rising edge (priority err > rty > ack):
    - ack: push m_wb_dat_i into the FIFO; tag last when this is word len-1; addr+1, remaining-1, retry_cnt=0, timeout=0. Remaining 0 → DRAIN; else CHECK. Cyc/stb drop for at least one cycle between words (classic single reads, no burst).
    - rty: retry_cnt+1. If retry_cnt was already MAX_RETRY → ABORT with status 10; else BACKOFF.
    - err: ABORT with status 01.
    - No termination: timeout counter+1. On reaching TIMEOUT → ABORT with status 11.
  - BACKOFF: cyc=stb=0 for exactly one cycle, then REQ at the same address. The timeout counter resets.
  - DRAIN:
    - Waits for the tx handshake (valid & ready) of the word tagged last.
    - That same cycle → IDLE, done_o=1, status=00, busy_o=0.
  - ABORT (one cycle):
    - cyc/stb low, FIFO flushed (tx_valid_o=0 next cycle).
    - done_o=1, busy_o=0 → IDLE.
- abort_i high in any non-IDLE state → ABORT with status 11 next cycle. An in-flight bus cycle is dropped: cyc low, and the late ack is ignored.
- start_i while busy is ignored. start_i and abort_i together in IDLE: start wins.
- Address wraps modulo 2^AW with no error.
- FIFO:
  - Simultaneous push and pop when full is not possible; CHECK guarantees space.
  - Simultaneous push and pop otherwise keeps occupancy.
  - tx_data_o, tx_valid_o and tx_last_o are registered from the FIFO head; they are stable while valid and not ready.
- Throughput: at most one word per 2 cycles with zero wait states.
- Latency: start → first stb is 2 cycles; ack → tx_valid_o is 1 cycle.

Test Plan:
- Zero-wait, len=4, adr=0x40, tx_ready=1, memory 0x11111111..0x44444444 → four single reads at 0x40..0x43; stream of the same 4 words with last on the 4th; done_o status 00.
- Slave wait_cyc=3, len=2, tx_ready held low for 20 cycles → each ack arrives 3 cycles after stb; FIFO holds 2 words; stream resumes intact; done fires only after the last word is accepted.
- Slave rty response, max slave retries 3 < MAX_RETRY=8 → 3 BACKOFF cycles, same address reissued, data correct, status 00. With MAX_RETRY=2 → abort after the 3rd rty, status 10, FIFO flushed.
- err on word 2 of 5 → cyc drops the next cycle, done_o with status 01, no further bus activity, tx_valid_o=0.
- Slave never responds (a_e_r_resp=000) → abort after 64 cycles, status 11. Separately, len=0 → done in 1 cycle with no cyc; start_adr=0xFFFFFFFF with len=2 → addresses FFFFFFFF then 00000000.
- Reset asserted mid-REQ with FIFO holding 3 words → all outputs 0 immediately, FIFO empty; a new start after release fetches normally.

Source files
------------

// File: rtl/wb_tx_frame_fetch.sv
`timescale 1ns/1ps
// Wishbone classic read master that fetches a frame of words into a small FIFO
// and streams them out with a last flag; handles wait states, retry, error and timeout.
module wb_tx_frame_fetch #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_RETRY  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start_i,
    input  logic [AW-1:0] start_adr_i,
    input  logic [15:0]   len_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    status_o,
    output logic [AW-1:0] m_wb_adr_o,
    output logic [3:0]    m_wb_sel_o,
    output logic          m_wb_we_o,
    output logic          m_wb_cyc_o,
    output logic          m_wb_stb_o,
    input  logic [DW-1:0] m_wb_dat_i,
    input  logic          m_wb_ack_i,
    input  logic          m_wb_err_i,
    input  logic          m_wb_rty_i,
    output logic [DW-1:0] tx_data_o,
    output logic          tx_valid_o,
    output logic          tx_last_o,
    input  logic          tx_ready_i
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_REQ     = 3'd2,
        S_BACKOFF = 3'd3,
        S_DRAIN   = 3'd4,
        S_ABORT   = 3'd5
    } state_t;

    state_t        state_r, next_state_s;
    logic [1:0]    abort_code_s;
    logic [AW-1:0] adr_r;
    logic [15:0]   rem_r;
    logic [RW-1:0] retry_r;
    logic [TW-1:0] to_r;

    logic [DW:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] out_data_r;
    logic          out_valid_r, out_last_r;

    logic          cyc_r, done_r, busy_r;
    logic [3:0]    sel_r;
    logic [1:0]    status_r;
    logic          cyc_nxt_s, done_nxt_s, busy_nxt_s;
    logic [1:0]    status_nxt_s;

    logic start_ok_s, in_req_s, term_rty_s, push_s, push_last_s;
    logic pop_s, last_hs_s, flush_s, load_out_s, mem_rd_s, mem_we_s;

    // An asserted abort_i masks every termination, so a late ack is never consumed.
    assign start_ok_s  = (state_r == S_IDLE) && start_i;
    assign in_req_s    = (state_r == S_REQ) && !abort_i;
    assign term_rty_s  = in_req_s && !m_wb_err_i && m_wb_rty_i;
    assign push_s      = in_req_s && !m_wb_err_i && !m_wb_rty_i && m_wb_ack_i;
    assign push_last_s = (rem_r == 16'd1);
    assign pop_s       = out_valid_r && tx_ready_i;
    assign last_hs_s   = pop_s && out_last_r;
    assign flush_s     = (next_state_s == S_ABORT);
    assign load_out_s  = !out_valid_r || pop_s;
    assign mem_rd_s    = load_out_s && (cnt_r != {CW{1'b0}});
    assign mem_we_s    = push_s && !(load_out_s && (cnt_r == {CW{1'b0}}));

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; termination priority is abort > err > rty > ack > timeout
    always_comb begin
        next_state_s = state_r;
        abort_code_s = 2'b11;
        case (state_r)
            S_IDLE: begin
                if (start_i && (len_i != 16'd0)) next_state_s = S_CHECK;
                else                             next_state_s = S_IDLE;
            end
            S_CHECK: begin
                if (abort_i)                            next_state_s = S_ABORT;
                else if (cnt_r < CW'(FIFO_DEPTH))       next_state_s = S_REQ;
                else                                    next_state_s = S_CHECK;
            end
            S_REQ: begin
                if (abort_i) begin
                    next_state_s = S_ABORT;
                end else if (m_wb_err_i) begin
                    next_state_s = S_ABORT;
                    abort_code_s = 2'b01;
                end else if (m_wb_rty_i) begin
                    if (retry_r == RW'(MAX_RETRY)) begin
                        next_state_s = S_ABORT;
                        abort_code_s = 2'b10;
                    end else begin
                        next_state_s = S_BACKOFF;
                    end
                end else if (m_wb_ack_i) begin
                    if (push_last_s) next_state_s = S_DRAIN;
                    else             next_state_s = S_CHECK;
                end else if (to_r == TW'(TIMEOUT - 1)) begin
                    next_state_s = S_ABORT;
                end else begin
                    next_state_s = S_REQ;
                end
            end
            S_BACKOFF: begin
                if (abort_i) next_state_s = S_ABORT;
                else         next_state_s = S_REQ;
            end
            S_DRAIN: begin
                if (abort_i)        next_state_s = S_ABORT;
                else if (last_hs_s) next_state_s = S_IDLE;
                else                next_state_s = S_DRAIN;
            end
            S_ABORT: next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every bus/status output is a flop
    always_comb begin
        cyc_nxt_s  = (next_state_s == S_REQ);
        busy_nxt_s = (next_state_s == S_CHECK) || (next_state_s == S_REQ) ||
                     (next_state_s == S_BACKOFF) || (next_state_s == S_DRAIN);
        done_nxt_s = (next_state_s == S_ABORT) ||
                     ((state_r == S_DRAIN) && (next_state_s == S_IDLE)) ||
                     (start_ok_s && (len_i == 16'd0));
        if (start_ok_s)                    status_nxt_s = 2'b00;
        else if (next_state_s == S_ABORT)  status_nxt_s = abort_code_s;
        else                               status_nxt_s = status_r;
    end

    // Output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cyc_r    <= 1'b0;
            sel_r    <= 4'h0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            status_r <= 2'b00;
        end else begin
            cyc_r    <= cyc_nxt_s;
            sel_r    <= cyc_nxt_s ? 4'hF : 4'h0;
            done_r   <= done_nxt_s;
            busy_r   <= busy_nxt_s;
            status_r <= status_nxt_s;
        end
    end

    // Address, remaining-word, retry and timeout counters
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            adr_r   <= {AW{1'b0}};
            rem_r   <= 16'd0;
            retry_r <= {RW{1'b0}};
            to_r    <= {TW{1'b0}};
        end else begin
            if (start_ok_s) begin
                adr_r   <= start_adr_i;
                rem_r   <= len_i;
                retry_r <= {RW{1'b0}};
            end else if (push_s) begin
                adr_r   <= adr_r + AW'(1'b1);
                rem_r   <= rem_r - 16'd1;
                retry_r <= {RW{1'b0}};
            end else if (term_rty_s && (retry_r != RW'(MAX_RETRY))) begin
                retry_r <= retry_r + RW'(1'b1);
            end
            if ((state_r == S_REQ) && (next_state_s == S_REQ)) to_r <= to_r + TW'(1'b1);
            else                                                to_r <= {TW{1'b0}};
        end
    end

    // FIFO storage; the output stage below is loaded directly when the storage is empty
    always_ff @(posedge wb_clk_i) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r] <= {push_last_s, m_wb_dat_i};
        end
    end

    // FIFO pointers and registered stream head
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            out_data_r  <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (flush_s) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            out_data_r  <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            if (mem_we_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            if (mem_rd_s) begin
                rd_ptr_r    <= rd_ptr_r + PW'(1'b1);
                out_data_r  <= mem_r[rd_ptr_r][DW-1:0];
                out_last_r  <= mem_r[rd_ptr_r][DW];
                out_valid_r <= 1'b1;
            end else if (load_out_s && push_s) begin
                out_data_r  <= m_wb_dat_i;
                out_last_r  <= push_last_s;
                out_valid_r <= 1'b1;
            end else if (load_out_s) begin
                out_valid_r <= 1'b0;
            end
            case ({mem_we_s, mem_rd_s})
                2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign status_o   = status_r;
    assign m_wb_adr_o = adr_r;
    assign m_wb_sel_o = sel_r;
    assign m_wb_we_o  = 1'b0;
    assign m_wb_cyc_o = cyc_r;
    assign m_wb_stb_o = cyc_r;
    assign tx_data_o  = out_data_r;
    assign tx_valid_o = out_valid_r;
    assign tx_last_o  = out_last_r;

endmodule
